// File: rtl/imu_sched_pkg.sv
// Shared types and helpers for the IMU sample scheduler: FSM state encoding,
// divider sizing and the sample-period calculation.
package imu_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        READ      = 3'd2,
        FILTER    = 3'd3,
        FUSE      = 3'd4,
        DONE      = 3'd5
    } sched_state_t;

    // Largest sample period the divider must cover (clock cycles per sample).
    localparam int unsigned MAX_PERIOD = 1 << 24;
    localparam int          DIV_W      = $clog2(MAX_PERIOD);

    function automatic int unsigned period_cycles(input int unsigned clk_hz,
                                                  input int unsigned sample_hz);
        return clk_hz / sample_hz;
    endfunction

endpackage

// File: rtl/imu_sample_scheduler_tick_gen.sv
// Sample-rate divider: counts 0..PERIOD-1 and flags the last count as the tick.
// Held at zero while hold_i is high so the first tick lands PERIOD cycles later.
module sched_tick_gen
    import imu_sched_pkg::*;
#(
    parameter int unsigned PERIOD = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic hold_i,
    output logic tick_o
);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(PERIOD - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = !hold_i && (cnt_q == LAST);

    always_comb begin
        if (hold_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imu_sample_scheduler.sv
// Rate-locked IMU read -> filter -> fusion sequencer with per-state watchdog and
// saturating overrun/timeout counters. Optional sample_seq output: IMU_SCHED_TIMESTAMP_EN.
module imu_sample_scheduler
    import imu_sched_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int SAMPLE_HZ    = 100,
    parameter int READ_TIMEOUT = 250000,
    parameter int PROC_TIMEOUT = 1024,
    parameter int CNT_W        = 8
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             enable,
    output logic             imu_req,
    input  logic             imu_done,
    output logic             filt_start,
    input  logic             lp_done,
    input  logic             hp_done,
    output logic             fuse_start,
    input  logic             fuse_done,
    output logic             sample_valid,
    output logic             busy,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    input  logic             clear_cnt
`ifdef IMU_SCHED_TIMESTAMP_EN
    ,
    output logic [15:0]      sample_seq
`endif
);
    localparam int unsigned     PERIOD    = period_cycles(CLK_HZ, SAMPLE_HZ);
    localparam int              WD_MAX    = (READ_TIMEOUT > PROC_TIMEOUT) ? READ_TIMEOUT : PROC_TIMEOUT;
    localparam int              WD_W      = $clog2(WD_MAX + 1);
    localparam logic [WD_W-1:0] READ_LAST = WD_W'(READ_TIMEOUT - 1);
    localparam logic [WD_W-1:0] PROC_LAST = WD_W'(PROC_TIMEOUT - 1);

    sched_state_t    state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            lp_seen_q, lp_seen_d;
    logic            hp_seen_q, hp_seen_d;
    logic            imu_req_q, filt_start_q, fuse_start_q, sample_valid_q;
    logic [CNT_W-1:0] overrun_q, timeout_q;
    logic            tick;
    logic            abort;
    logic            entering;
    logic            overrun_inc;

    sched_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick_gen (
        .clk_i  (CLOCK_50),
        .rst_i  (RESET),
        .hold_i (state_q == IDLE),
        .tick_o (tick)
    );

    assign busy        = (state_q == READ) || (state_q == FILTER) ||
                         (state_q == FUSE) || (state_q == DONE);
    assign overrun_inc = tick && busy;
    assign entering    = (state_d != state_q);

    // Done inputs win over a watchdog expiry landing on the same cycle.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (!enable)   state_d = IDLE;
                else if (tick) state_d = READ;
            end
            READ: begin
                if (imu_done)                state_d = FILTER;
                else if (wd_q == READ_LAST)  abort = 1'b1;
            end
            FILTER: begin
                if ((lp_seen_q || lp_done) && (hp_seen_q || hp_done)) state_d = FUSE;
                else if (wd_q == PROC_LAST)  abort = 1'b1;
            end
            FUSE: begin
                if (fuse_done)               state_d = DONE;
                else if (wd_q == PROC_LAST)  abort = 1'b1;
            end
            DONE: begin
                state_d = enable ? WAIT_TICK : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = enable ? WAIT_TICK : IDLE;
    end

    always_comb begin
        wd_d      = '0;
        lp_seen_d = lp_seen_q;
        hp_seen_d = hp_seen_q;
        if (!entering && ((state_q == READ) || (state_q == FILTER) || (state_q == FUSE))) begin
            wd_d = wd_q + 1'b1;
        end
        if (entering && (state_d == FILTER)) begin
            lp_seen_d = 1'b0;
            hp_seen_d = 1'b0;
        end else if (state_q == FILTER) begin
            lp_seen_d = lp_seen_q || lp_done;
            hp_seen_d = hp_seen_q || hp_done;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q        <= IDLE;
            wd_q           <= '0;
            lp_seen_q      <= 1'b0;
            hp_seen_q      <= 1'b0;
            imu_req_q      <= 1'b0;
            filt_start_q   <= 1'b0;
            fuse_start_q   <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wd_q           <= wd_d;
            lp_seen_q      <= lp_seen_d;
            hp_seen_q      <= hp_seen_d;
            imu_req_q      <= entering && (state_d == READ);
            filt_start_q   <= entering && (state_d == FILTER);
            fuse_start_q   <= entering && (state_d == FUSE);
            sample_valid_q <= entering && (state_d == DONE);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            overrun_q <= '0;
            timeout_q <= '0;
        end else if (clear_cnt) begin
            overrun_q <= '0;
            timeout_q <= '0;
        end else begin
            if (overrun_inc && (overrun_q != '1)) overrun_q <= overrun_q + 1'b1;
            if (abort && (timeout_q != '1))       timeout_q <= timeout_q + 1'b1;
        end
    end

    assign imu_req      = imu_req_q;
    assign filt_start   = filt_start_q;
    assign fuse_start   = fuse_start_q;
    assign sample_valid = sample_valid_q;
    assign overrun_cnt  = overrun_q;
    assign timeout_cnt  = timeout_q;

`ifdef IMU_SCHED_TIMESTAMP_EN
    logic [15:0] seq_q;

    // Bumped on the edge that enters DONE so the sample_valid cycle shows the new value.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            seq_q <= '0;
        end else if (entering && (state_d == DONE)) begin
            seq_q <= seq_q + 16'd1;
        end
    end

    assign sample_seq = seq_q;
`endif

endmodule

// File: tb/tb_imu_sample_scheduler.sv
// Directed bench for imu_sample_scheduler at PERIOD=10, READ_TIMEOUT=20, PROC_TIMEOUT=8.
module tb_imu_sample_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       imu_done = 1'b0;
    logic       lp_done = 1'b0;
    logic       hp_done = 1'b0;
    logic       fuse_done = 1'b0;
    logic       clear_cnt = 1'b0;
    logic       imu_req, filt_start, fuse_start, sample_valid, busy;
    logic [7:0] overrun_cnt, timeout_cnt;
`ifdef IMU_SCHED_TIMESTAMP_EN
    logic [15:0] sample_seq;
    int          seq_exp = 0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_req  = 0;
    int cnt_filt = 0;
    int cnt_fuse = 0;
    int cnt_sv   = 0;

    always #5 clk = ~clk;

    imu_sample_scheduler #(
        .CLK_HZ       (1000),
        .SAMPLE_HZ    (100),
        .READ_TIMEOUT (20),
        .PROC_TIMEOUT (8),
        .CNT_W        (8)
    ) dut (
        .CLOCK_50     (clk),
        .RESET        (rst),
        .enable       (enable),
        .imu_req      (imu_req),
        .imu_done     (imu_done),
        .filt_start   (filt_start),
        .lp_done      (lp_done),
        .hp_done      (hp_done),
        .fuse_start   (fuse_start),
        .fuse_done    (fuse_done),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt),
        .timeout_cnt  (timeout_cnt),
        .clear_cnt    (clear_cnt)
`ifdef IMU_SCHED_TIMESTAMP_EN
        ,
        .sample_seq   (sample_seq)
`endif
    );

    // Pulse tally, sampled mid-cycle.
    always @(negedge clk) begin
        if (imu_req)      cnt_req  <= cnt_req + 1;
        if (filt_start)   cnt_filt <= cnt_filt + 1;
        if (fuse_start)   cnt_fuse <= cnt_fuse + 1;
        if (sample_valid) cnt_sv   <= cnt_sv + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!imu_req && (n < budget));
        chk({tag, " req_seen"}, imu_req, 1);
    endtask

    // One pass; delays are cycles from the matching start pulse to its done pulse.
    task automatic run_pass(input string tag, input int exp_wait, input int imu_d,
                            input int lp_d, input int hp_d, input int fu_d, input bit drop_en);
        int n, c_filt, c_fuse, last;
        wait_req(tag, exp_wait + 5, n);
        chk({tag, " req_wait"}, n, exp_wait);
        if (drop_en) enable = 1'b0;
        c_filt = cnt_filt;
        c_fuse = cnt_fuse;
        repeat (imu_d) step();
        imu_done = 1'b1;
        step();
        imu_done = 1'b0;
        chk({tag, " filt_start"}, filt_start, 1);
        last = (lp_d > hp_d) ? lp_d : hp_d;
        for (int i = 0; i <= last; i++) begin
            lp_done = (i == lp_d);
            hp_done = (i == hp_d);
            step();
        end
        lp_done = 1'b0;
        hp_done = 1'b0;
        chk({tag, " fuse_start"}, fuse_start, 1);
        repeat (fu_d) step();
        fuse_done = 1'b1;
        step();
        fuse_done = 1'b0;
        chk({tag, " sample_valid"}, sample_valid, 1);
        chk({tag, " filt_once"}, cnt_filt - c_filt, 1);
        chk({tag, " fuse_once"}, cnt_fuse - c_fuse, 1);
`ifdef IMU_SCHED_TIMESTAMP_EN
        seq_exp = (seq_exp + 1) % 65536;
        chk({tag, " sample_seq"}, sample_seq, seq_exp);
`endif
        step();
        chk({tag, " sv_one_cycle"}, sample_valid, 0);
        chk({tag, " busy_after"}, busy, 0);
        $display("pass %s: req_wait=%0d overrun=%0d timeout=%0d", tag, n, overrun_cnt, timeout_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n, sv0, req0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst imu_req", imu_req, 0);
        chk("rst filt_start", filt_start, 0);
        chk("rst fuse_start", fuse_start, 0);
        chk("rst sample_valid", sample_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst overrun", overrun_cnt, 0);
        chk("rst timeout", timeout_cnt, 0);

        rst = 1'b0;
        repeat (15) step();
        chk("idle no_req", cnt_req, 0);
        chk("idle busy", busy, 0);

        // First tick 10 edges after the edge that samples enable -> 11th step.
        enable = 1'b1;
        run_pass("nom1", 11, 3, 0, 0, 2, 1'b0);
        run_pass("nom2", 1, 3, 0, 0, 2, 1'b0);
        chk("nom overrun", overrun_cnt, 0);
        chk("nom timeout", timeout_cnt, 0);

        run_pass("split", 1, 0, 1, 5, 0, 1'b0);
        chk("split overrun", overrun_cnt, 0);

        // READ timeout: 20 READ cycles, ticks at READ cycles 9 and 19 are overruns.
        wait_req("to", 6, n);
        chk("to req_wait", n, 1);
        sv0 = cnt_sv;
        repeat (19) step();
        chk("to busy_last", busy, 1);
        chk("to cnt_before", timeout_cnt, 0);
        step();
        chk("to busy_after", busy, 0);
        chk("to timeout_cnt", timeout_cnt, 1);
        chk("to overrun_cnt", overrun_cnt, 2);
        chk("to no_sv", cnt_sv - sv0, 0);
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        chk("clr overrun", overrun_cnt, 0);
        chk("clr timeout", timeout_cnt, 0);
        run_pass("after_to", 9, 3, 0, 0, 2, 1'b0);

        // fuse_done held off 7 cycles: the tick lands in FUSE.
        run_pass("ovr", 1, 0, 0, 0, 7, 1'b0);
        chk("ovr overrun", overrun_cnt, 1);
        chk("ovr timeout", timeout_cnt, 0);

        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        wait_req("sat", 13, n);
        chk("sat req_wait", n, 8);
        // 150 READ timeouts x 2 busy ticks = 300 overruns, saturating at 255.
        repeat (4500) step();
        chk("sat req_again", imu_req, 1);
        chk("sat overrun", overrun_cnt, 255);
        chk("sat timeout", timeout_cnt, 150);
        repeat (9) step();
        clear_cnt = 1'b1;
        step();
        clear_cnt = 1'b0;
        chk("clr_prio overrun", overrun_cnt, 0);
        chk("clr_prio timeout", timeout_cnt, 0);
        repeat (10) step();
        chk("post_clr overrun", overrun_cnt, 1);
        chk("post_clr timeout", timeout_cnt, 1);

        wait_req("rstf", 15, n);
        chk("rstf req_wait", n, 10);
        imu_done = 1'b1;
        step();
        imu_done = 1'b0;
        chk("rstf filt_pre", filt_start, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstf filt_start", filt_start, 0);
        chk("rstf busy", busy, 0);
        chk("rstf imu_req", imu_req, 0);
        chk("rstf overrun", overrun_cnt, 0);
        chk("rstf timeout", timeout_cnt, 0);
        step();
        rst = 1'b0;
`ifdef IMU_SCHED_TIMESTAMP_EN
        seq_exp = 0;
`endif
        run_pass("post_rst", 11, 3, 0, 0, 2, 1'b0);

        run_pass("drop_en", 1, 3, 0, 0, 2, 1'b1);
        req0 = cnt_req;
        repeat (25) step();
        chk("drop_en no_req", cnt_req - req0, 0);
        chk("drop_en busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
